dispatch_ctrl: RTL and testbench
================================

# dispatch_ctrl

Front-end dispatch controller between the instruction fetcher and the out-of-order back end. It buffers fetched instructions in a small queue, presents the queue head to the combinational decoder, and issues each decoded instruction to the reservation station (RS) or load/store buffer (LSB) while allocating a reorder buffer (ROB) entry. It stalls on back-end back-pressure, stops dispatching after a JALR until the target resolves, and flushes on mispredict.

## Interface
- IQ_DEPTH, 4: instruction queue entries (power of two).
- ROB_IDX_W, 4: ROB tag width.
- clk_in  in  1  clock, rising edge.
- rst_n_in  in  1  asynchronous active-low reset.
- rdy_in  in  1  global enable; low freezes all state, including flush.
- if_valid_in  in  1  fetcher pushes one instruction.
- if_inst_in / if_pc_in  in  32 / 32  instruction word and its PC.
- if_pred_jump_in  in  1  predictor taken bit for the instruction.
- iq_full_out  out  1  queue count == IQ_DEPTH.
- dec_inst_out  out  32  queue-head word to decoder; 0 when the queue is empty.
- dec_openum_in, dec_rd_in, dec_rs1_in, dec_rs2_in, dec_imm_in, dec_is_jump_in, dec_is_store_in  in  decoder widths  decoder results for dec_inst_out.
- rob_full_in, rs_full_in, lsb_full_in  in  1  back-pressure.
- rob_tag_in  in  ROB_IDX_W  next free ROB tag.
- jalr_done_in  in  1  JALR target resolved.
- flush_in  in  1  mispredict flush.
- rob_alloc_out, rs_issue_out, lsb_issue_out  out  1  one-cycle issue pulses.
- disp_openum_out, disp_rd_out, disp_rs1_out, disp_rs2_out, disp_imm_out, disp_pc_out, disp_tag_out, disp_pred_jump_out  out  decoder widths / 32 / ROB_IDX_W / 1  registered dispatch packet.
- jalr_wait_out  out  1  FSM is in WAIT_JALR.

## Operation
- Queue: circular FIFO with head and tail pointers that wrap modulo IQ_DEPTH, plus a count register.
  - A push is accepted when if_valid_in is high and count < IQ_DEPTH. A push while full is dropped.
  - Full is judged on the registered count, so there is no push bypass on the cycle a pop occurs while full.
- FSM states: RUN and WAIT_JALR.
- Dispatch condition: state is RUN, the queue is non-empty, rob_full_in is 0, and the target unit is not full.
  - Target is the LSB when opcode == 0000011 (load) or dec_is_store_in is set; otherwise the RS.
- On dispatch:
  - Pop the head.
  - Register all decoder fields, PC, pred bit and rob_tag_in into disp_*.
  - Pulse rob_alloc_out plus exactly one of rs_issue_out or lsb_issue_out.
- If dec_openum_in == NOP (illegal or unknown opcode), the head is popped with no pulses and no ROB allocation.
- If the dispatched openum is JALR, the FSM goes RUN -> WAIT_JALR.
  - In WAIT_JALR, the queue still accepts pushes but nothing is dispatched.
  - WAIT_JALR -> RUN on jalr_done_in or flush_in.
- Flush has priority over push, pop and dispatch in the same cycle:
  - count, head and tail are set to 0; state goes to RUN.
  - Issue pulses are 0 in the following cycle.
- Reset values:
  - count, pointers and all outputs are 0; state is RUN.
  - iq_full_out is 0 and dec_inst_out is 0.

## Timing
- Issue pulses and disp_* are registered.
  - Instruction pushed at edge N is visible at the head from cycle N+1.
  - If resources are free, its pulses are high during cycle N+2.
- Sustained throughput is one dispatch per cycle.
- Pulses last exactly one cycle. disp_* hold their value until the next dispatch.
- Back-pressure is sampled in the dispatch cycle. A full signal asserted in the same cycle blocks the dispatch.
- Simultaneous push and pop with count < IQ_DEPTH leaves count unchanged.
- rdy_in low: no state change and pulses are forced to 0. Asynchronous reset still acts.
- Reset asserted mid-dispatch clears the in-flight pulse immediately (asynchronous).

## Test plan
- Push ADDI x1,x0,5 (0x00500093): rs_issue_out=1 and rob_alloc_out=1 exactly two cycles later; disp_rd_out=1, disp_imm_out=5, disp_tag_out=rob_tag_in.
- Push LW then SW with rs_full_in=1: both go to the LSB on consecutive cycles and rs_issue_out stays 0.
- Fill the queue with 4 instructions while rob_full_in=1:
  - iq_full_out=1 and a fifth push is dropped.
  - Releasing rob_full_in issues exactly 4 instructions, in order, with the PC sequence preserved across pointer wrap.
- JALR followed by ADDI:
  - jalr_wait_out=1 and the ADDI is held.
  - jalr_done_in pulse -> ADDI issues on the next cycle.
- flush_in asserted in the same cycle as a push and a possible dispatch: queue empty, no pulse next cycle, FSM in RUN, and a new push dispatches normally afterwards.
- Push an illegal opcode 0xFFFFFFFF: popped with no pulses; the following ADDI issues one cycle later.

Source files
------------

// File: rtl/dispatch_ctrl.sv
`timescale 1ns/1ps
// dispatch_ctrl: small instruction queue feeding an external decoder, and a RUN/WAIT_JALR
// dispatcher that issues each decoded head to the RS or LSB while allocating a ROB entry.
module dispatch_ctrl #(
    parameter int                  IQ_DEPTH    = 4,
    parameter int                  ROB_IDX_W   = 4,
    parameter int                  OPENUM_W    = 6,
    parameter logic [OPENUM_W-1:0] OPENUM_NOP  = OPENUM_W'(0),
    parameter logic [OPENUM_W-1:0] OPENUM_JALR = OPENUM_W'(3)
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 rdy_in,
    input  logic                 if_valid_in,
    input  logic [31:0]          if_inst_in,
    input  logic [31:0]          if_pc_in,
    input  logic                 if_pred_jump_in,
    output logic                 iq_full_out,
    output logic [31:0]          dec_inst_out,
    input  logic [OPENUM_W-1:0]  dec_openum_in,
    input  logic [4:0]           dec_rd_in,
    input  logic [4:0]           dec_rs1_in,
    input  logic [4:0]           dec_rs2_in,
    input  logic [31:0]          dec_imm_in,
    input  logic                 dec_is_jump_in,
    input  logic                 dec_is_store_in,
    input  logic                 rob_full_in,
    input  logic                 rs_full_in,
    input  logic                 lsb_full_in,
    input  logic [ROB_IDX_W-1:0] rob_tag_in,
    input  logic                 jalr_done_in,
    input  logic                 flush_in,
    output logic                 rob_alloc_out,
    output logic                 rs_issue_out,
    output logic                 lsb_issue_out,
    output logic [OPENUM_W-1:0]  disp_openum_out,
    output logic [4:0]           disp_rd_out,
    output logic [4:0]           disp_rs1_out,
    output logic [4:0]           disp_rs2_out,
    output logic [31:0]          disp_imm_out,
    output logic [31:0]          disp_pc_out,
    output logic [ROB_IDX_W-1:0] disp_tag_out,
    output logic                 disp_pred_jump_out,
    output logic                 jalr_wait_out
);

    localparam int               PTR_W    = $clog2(IQ_DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(IQ_DEPTH);
    localparam logic [6:0]       OPC_LOAD = 7'b0000011;

    typedef enum logic [0:0] {
        S_RUN       = 1'b0,
        S_WAIT_JALR = 1'b1
    } state_t;

    logic [31:0]          r_iq_inst [IQ_DEPTH];
    logic [31:0]          r_iq_pc   [IQ_DEPTH];
    logic [IQ_DEPTH-1:0]  r_iq_pred;
    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [CNT_W-1:0]     r_count;
    state_t               r_state;

    logic                 r_rob_alloc;
    logic                 r_rs_issue;
    logic                 r_lsb_issue;
    logic [OPENUM_W-1:0]  r_disp_openum;
    logic [4:0]           r_disp_rd;
    logic [4:0]           r_disp_rs1;
    logic [4:0]           r_disp_rs2;
    logic [31:0]          r_disp_imm;
    logic [31:0]          r_disp_pc;
    logic [ROB_IDX_W-1:0] r_disp_tag;
    logic                 r_disp_pred;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_adv;
    logic [31:0]          w_head_inst;
    logic                 w_is_nop;
    logic                 w_is_jalr;
    logic                 w_to_lsb;
    logic                 w_unit_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_issue;

    // Fullness uses the registered count only: a pop never frees room for a same-cycle push.
    assign w_empty     = (r_count == {CNT_W{1'b0}});
    assign w_full      = (r_count == FULL_CNT);
    assign w_adv       = rdy_in && !flush_in;
    assign w_head_inst = r_iq_inst[r_head];
    assign w_is_nop    = (dec_openum_in == OPENUM_NOP);
    assign w_is_jalr   = (dec_openum_in == OPENUM_JALR) && dec_is_jump_in;
    assign w_to_lsb    = (w_head_inst[6:0] == OPC_LOAD) || dec_is_store_in;
    assign w_unit_full = w_to_lsb ? lsb_full_in : rs_full_in;
    assign w_push      = w_adv && if_valid_in && !w_full;
    // Unknown opcodes drain without needing any back-end resource.
    assign w_pop       = w_adv && (r_state == S_RUN) && !w_empty &&
                         (w_is_nop || (!rob_full_in && !w_unit_full));
    assign w_issue     = w_pop && !w_is_nop;

    assign iq_full_out  = w_full;
    assign dec_inst_out = w_empty ? 32'd0 : w_head_inst;

    // Instruction queue storage, pointers and occupancy count.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_head    <= {PTR_W{1'b0}};
            r_tail    <= {PTR_W{1'b0}};
            r_count   <= {CNT_W{1'b0}};
            r_iq_pred <= {IQ_DEPTH{1'b0}};
            for (int i = 0; i < IQ_DEPTH; i++) begin
                r_iq_inst[i] <= 32'd0;
                r_iq_pc[i]   <= 32'd0;
            end
        end else if (rdy_in && flush_in) begin
            r_head  <= {PTR_W{1'b0}};
            r_tail  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_iq_inst[r_tail] <= if_inst_in;
                r_iq_pc[r_tail]   <= if_pc_in;
                r_iq_pred[r_tail] <= if_pred_jump_in;
                r_tail            <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Dispatch FSM with registered issue pulses and dispatch packet.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state       <= S_RUN;
            r_rob_alloc   <= 1'b0;
            r_rs_issue    <= 1'b0;
            r_lsb_issue   <= 1'b0;
            r_disp_openum <= {OPENUM_W{1'b0}};
            r_disp_rd     <= 5'd0;
            r_disp_rs1    <= 5'd0;
            r_disp_rs2    <= 5'd0;
            r_disp_imm    <= 32'd0;
            r_disp_pc     <= 32'd0;
            r_disp_tag    <= {ROB_IDX_W{1'b0}};
            r_disp_pred   <= 1'b0;
        end else if (!rdy_in) begin
            r_rob_alloc <= 1'b0;
            r_rs_issue  <= 1'b0;
            r_lsb_issue <= 1'b0;
        end else if (flush_in) begin
            r_state     <= S_RUN;
            r_rob_alloc <= 1'b0;
            r_rs_issue  <= 1'b0;
            r_lsb_issue <= 1'b0;
        end else begin
            r_rob_alloc <= w_issue;
            r_rs_issue  <= w_issue && !w_to_lsb;
            r_lsb_issue <= w_issue && w_to_lsb;
            case (r_state)
                S_RUN: begin
                    if (w_issue && w_is_jalr) begin
                        r_state <= S_WAIT_JALR;
                    end
                end
                S_WAIT_JALR: begin
                    if (jalr_done_in) begin
                        r_state <= S_RUN;
                    end
                end
                default: r_state <= S_RUN;
            endcase
            if (w_issue) begin
                r_disp_openum <= dec_openum_in;
                r_disp_rd     <= dec_rd_in;
                r_disp_rs1    <= dec_rs1_in;
                r_disp_rs2    <= dec_rs2_in;
                r_disp_imm    <= dec_imm_in;
                r_disp_pc     <= r_iq_pc[r_head];
                r_disp_tag    <= rob_tag_in;
                r_disp_pred   <= r_iq_pred[r_head];
            end
        end
    end

    assign rob_alloc_out      = r_rob_alloc;
    assign rs_issue_out       = r_rs_issue;
    assign lsb_issue_out      = r_lsb_issue;
    assign disp_openum_out    = r_disp_openum;
    assign disp_rd_out        = r_disp_rd;
    assign disp_rs1_out       = r_disp_rs1;
    assign disp_rs2_out       = r_disp_rs2;
    assign disp_imm_out       = r_disp_imm;
    assign disp_pc_out        = r_disp_pc;
    assign disp_tag_out       = r_disp_tag;
    assign disp_pred_jump_out = r_disp_pred;
    assign jalr_wait_out      = (r_state == S_WAIT_JALR);

endmodule

// File: tb/tb_dispatch_ctrl.sv
`timescale 1ns/1ps
// tb_dispatch_ctrl: directed cases then random traffic, compared each cycle against a
// queue-based model of the dispatch rules; the bench also plays the combinational decoder.
module tb_dispatch_ctrl;

    localparam int         IQ_DEPTH  = 4;
    localparam int         ROB_IDX_W = 4;
    localparam logic [5:0] OP_NOP    = 6'd0;
    localparam logic [5:0] OP_ADDI   = 6'd1;
    localparam logic [5:0] OP_LW     = 6'd2;
    localparam logic [5:0] OP_JALR   = 6'd3;
    localparam logic [5:0] OP_SW     = 6'd4;
    localparam logic [5:0] OP_ADD    = 6'd5;
    localparam logic [31:0] I_ADDI   = 32'h00500093;
    localparam logic [31:0] I_LW     = 32'h00012083;
    localparam logic [31:0] I_SW     = 32'h00112223;
    localparam logic [31:0] I_JALR   = 32'h000080e7;
    localparam logic [31:0] I_ADD    = 32'h002081b3;
    localparam logic [31:0] I_ILL    = 32'hffffffff;

    typedef struct packed {
        logic [5:0]  openum;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        is_jump;
        logic        is_store;
    } dec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } ent_t;

    logic                 clk_s;
    logic                 rst_n_s;
    logic                 rdy_s;
    logic                 valid_s;
    logic [31:0]          inst_s;
    logic [31:0]          pc_s;
    logic                 pred_s;
    logic                 rob_full_s;
    logic                 rs_full_s;
    logic                 lsb_full_s;
    logic [ROB_IDX_W-1:0] tag_s;
    logic                 done_s;
    logic                 flush_s;

    logic                 iq_full_w;
    logic [31:0]          dec_inst_w;
    dec_t                 dec_s;
    logic                 rob_alloc_w;
    logic                 rs_issue_w;
    logic                 lsb_issue_w;
    logic [5:0]           disp_openum_w;
    logic [4:0]           disp_rd_w;
    logic [4:0]           disp_rs1_w;
    logic [4:0]           disp_rs2_w;
    logic [31:0]          disp_imm_w;
    logic [31:0]          disp_pc_w;
    logic [ROB_IDX_W-1:0] disp_tag_w;
    logic                 disp_pred_w;
    logic                 jalr_wait_w;

    int n_cmp;
    int n_err;
    int n_issued;

    ent_t                 mq[$];
    bit                   m_wait;
    logic                 m_alloc;
    logic                 m_rs;
    logic                 m_lsb;
    dec_t                 m_d;
    logic [31:0]          m_pc;
    logic                 m_pred;
    logic [ROB_IDX_W-1:0] m_tag;

    function automatic dec_t decode(input logic [31:0] w);
        dec_t d;
        d     = '0;
        d.rd  = w[11:7];
        d.rs1 = w[19:15];
        d.rs2 = w[24:20];
        d.imm = {{20{w[31]}}, w[31:20]};
        case (w[6:0])
            7'b0010011: d.openum = OP_ADDI;
            7'b0000011: d.openum = OP_LW;
            7'b1100111: begin
                d.openum  = OP_JALR;
                d.is_jump = 1'b1;
            end
            7'b0100011: begin
                d.openum   = OP_SW;
                d.is_store = 1'b1;
                d.rd       = 5'd0;
                d.imm      = {{20{w[31]}}, w[31:25], w[11:7]};
            end
            7'b0110011: begin
                d.openum = OP_ADD;
                d.imm    = 32'd0;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  op;
        r = $urandom;
        case ($urandom_range(0, 5))
            0:       op = 7'b0010011;
            1:       op = 7'b0000011;
            2:       op = 7'b1100111;
            3:       op = 7'b0100011;
            4:       op = 7'b0110011;
            default: op = 7'b1111111;
        endcase
        return {r[31:7], op};
    endfunction

    assign dec_s = decode(dec_inst_w);

    dispatch_ctrl #(.IQ_DEPTH(IQ_DEPTH), .ROB_IDX_W(ROB_IDX_W)) u_dut (
        .clk_in             (clk_s),
        .rst_n_in           (rst_n_s),
        .rdy_in             (rdy_s),
        .if_valid_in        (valid_s),
        .if_inst_in         (inst_s),
        .if_pc_in           (pc_s),
        .if_pred_jump_in    (pred_s),
        .iq_full_out        (iq_full_w),
        .dec_inst_out       (dec_inst_w),
        .dec_openum_in      (dec_s.openum),
        .dec_rd_in          (dec_s.rd),
        .dec_rs1_in         (dec_s.rs1),
        .dec_rs2_in         (dec_s.rs2),
        .dec_imm_in         (dec_s.imm),
        .dec_is_jump_in     (dec_s.is_jump),
        .dec_is_store_in    (dec_s.is_store),
        .rob_full_in        (rob_full_s),
        .rs_full_in         (rs_full_s),
        .lsb_full_in        (lsb_full_s),
        .rob_tag_in         (tag_s),
        .jalr_done_in       (done_s),
        .flush_in           (flush_s),
        .rob_alloc_out      (rob_alloc_w),
        .rs_issue_out       (rs_issue_w),
        .lsb_issue_out      (lsb_issue_w),
        .disp_openum_out    (disp_openum_w),
        .disp_rd_out        (disp_rd_w),
        .disp_rs1_out       (disp_rs1_w),
        .disp_rs2_out       (disp_rs2_w),
        .disp_imm_out       (disp_imm_w),
        .disp_pc_out        (disp_pc_w),
        .disp_tag_out       (disp_tag_w),
        .disp_pred_jump_out (disp_pred_w),
        .jalr_wait_out      (jalr_wait_w)
    );

    initial clk_s = 1'b0;
    always #5 clk_s = ~clk_s;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_wait  = 1'b0;
        m_alloc = 1'b0;
        m_rs    = 1'b0;
        m_lsb   = 1'b0;
        m_d     = '0;
        m_pc    = 32'd0;
        m_pred  = 1'b0;
        m_tag   = '0;
    endtask

    // One clock of the reference: dispatch from the old queue contents, then admit the push.
    task automatic model_step();
        ent_t e;
        dec_t d;
        bit   was_full;
        bit   lsb;
        if (!rst_n_s) begin
            model_reset();
            return;
        end
        m_alloc = 1'b0;
        m_rs    = 1'b0;
        m_lsb   = 1'b0;
        if (!rdy_s) return;
        if (flush_s) begin
            mq.delete();
            m_wait = 1'b0;
            return;
        end
        was_full = (mq.size() == IQ_DEPTH);
        if (m_wait) begin
            if (done_s) m_wait = 1'b0;
        end else if (mq.size() != 0) begin
            e   = mq[0];
            d   = decode(e.inst);
            lsb = (e.inst[6:0] == 7'b0000011) || d.is_store;
            if (d.openum == OP_NOP) begin
                void'(mq.pop_front());
            end else if (!rob_full_s && !(lsb ? lsb_full_s : rs_full_s)) begin
                void'(mq.pop_front());
                m_alloc = 1'b1;
                m_rs    = !lsb;
                m_lsb   = lsb;
                m_d     = d;
                m_pc    = e.pc;
                m_pred  = e.pred;
                m_tag   = tag_s;
                if (d.openum == OP_JALR) m_wait = 1'b1;
            end
        end
        if (valid_s && !was_full) begin
            e.inst = inst_s;
            e.pc   = pc_s;
            e.pred = pred_s;
            mq.push_back(e);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] exp_inst;
        exp_inst = 32'd0;
        if (mq.size() != 0) exp_inst = mq[0].inst;
        check_val("rob_alloc", rob_alloc_w, m_alloc);
        check_val("rs_issue", rs_issue_w, m_rs);
        check_val("lsb_issue", lsb_issue_w, m_lsb);
        check_val("jalr_wait", jalr_wait_w, m_wait);
        check_val("iq_full", iq_full_w, mq.size() == IQ_DEPTH);
        check_val("dec_inst", dec_inst_w, exp_inst);
        check_val("disp_openum", disp_openum_w, m_d.openum);
        check_val("disp_rd", disp_rd_w, m_d.rd);
        check_val("disp_rs1", disp_rs1_w, m_d.rs1);
        check_val("disp_rs2", disp_rs2_w, m_d.rs2);
        check_val("disp_imm", disp_imm_w, m_d.imm);
        check_val("disp_pc", disp_pc_w, m_pc);
        check_val("disp_tag", disp_tag_w, m_tag);
        check_val("disp_pred", disp_pred_w, m_pred);
    endtask

    task automatic tick();
        @(posedge clk_s);
        model_step();
        @(negedge clk_s);
        check_outputs();
    endtask

    task automatic idle();
        valid_s    = 1'b0;
        inst_s     = 32'd0;
        pc_s       = 32'd0;
        pred_s     = 1'b0;
        rob_full_s = 1'b0;
        rs_full_s  = 1'b0;
        lsb_full_s = 1'b0;
        done_s     = 1'b0;
        flush_s    = 1'b0;
        rdy_s      = 1'b1;
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pc);
        valid_s = 1'b1;
        inst_s  = inst;
        pc_s    = pc;
        pred_s  = pc[2];
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: sim time observed 500000ns, expected finish earlier");
        $fatal(1, "time limit");
    end

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst_n_s = 1'b0;
        tag_s   = '0;
        idle();
        model_reset();
        #1;
        check_val("reset_alloc", rob_alloc_w, 1'b0);
        check_val("reset_iq_full", iq_full_w, 1'b0);
        check_val("reset_dec_inst", dec_inst_w, 32'd0);
        check_val("reset_jalr_wait", jalr_wait_w, 1'b0);
        repeat (2) tick();
        rst_n_s = 1'b1;

        // ADDI x1,x0,5: issue two cycles after the push, then reset while the pulse is high
        tag_s = 4'h9;
        push(I_ADDI, 32'h100);
        tick();
        idle();
        tick();
        check_val("addi_rs", rs_issue_w, 1'b1);
        check_val("addi_rob", rob_alloc_w, 1'b1);
        check_val("addi_rd", disp_rd_w, 5'd1);
        check_val("addi_imm", disp_imm_w, 32'd5);
        check_val("addi_tag", disp_tag_w, 4'h9);
        #1;
        rst_n_s = 1'b0;
        #1;
        check_val("rst_mid_alloc", rob_alloc_w, 1'b0);
        check_val("rst_mid_rs", rs_issue_w, 1'b0);
        tick();
        rst_n_s = 1'b1;

        // LW then SW while the RS is full
        rs_full_s = 1'b1;
        push(I_LW, 32'h200);
        tick();
        push(I_SW, 32'h204);
        tick();
        check_val("lw_lsb", lsb_issue_w, 1'b1);
        idle();
        rs_full_s = 1'b1;
        tick();
        check_val("sw_lsb", lsb_issue_w, 1'b1);
        check_val("sw_rs", rs_issue_w, 1'b0);
        check_val("sw_pc", disp_pc_w, 32'h204);
        idle();
        tick();

        // fill while the ROB is full; fifth push dropped; drain across pointer wrap
        rob_full_s = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(I_ADD, 32'h300 + 32'(4 * i));
            tick();
        end
        check_val("fill_full", iq_full_w, 1'b1);
        idle();
        n_issued = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rob_alloc_w) n_issued++;
        end
        check_val("fill_issued", 64'(n_issued), 64'd4);
        check_val("fill_last_pc", disp_pc_w, 32'h30c);

        // JALR holds the following ADDI until jalr_done
        push(I_JALR, 32'h400);
        tick();
        push(I_ADDI, 32'h404);
        tick();
        idle();
        tick();
        check_val("jalr_wait_set", jalr_wait_w, 1'b1);
        check_val("jalr_hold", rob_alloc_w, 1'b0);
        done_s = 1'b1;
        tick();
        idle();
        tick();
        check_val("jalr_release_rs", rs_issue_w, 1'b1);
        check_val("jalr_release_pc", disp_pc_w, 32'h404);

        // flush beats a same-cycle push and dispatch
        push(I_ADDI, 32'h500);
        tick();
        push(I_ADDI, 32'h504);
        flush_s = 1'b1;
        tick();
        check_val("flush_pulse", rob_alloc_w, 1'b0);
        check_val("flush_empty", dec_inst_w, 32'd0);
        idle();
        tick();
        check_val("flush_next", rob_alloc_w, 1'b0);
        push(I_ADDI, 32'h508);
        tick();
        idle();
        tick();
        check_val("flush_after_pc", disp_pc_w, 32'h508);

        // illegal word drains with no pulse
        push(I_ILL, 32'h600);
        tick();
        push(I_ADDI, 32'h604);
        tick();
        check_val("ill_pulse", rob_alloc_w, 1'b0);
        idle();
        tick();
        check_val("ill_next_rs", rs_issue_w, 1'b1);
        check_val("ill_next_pc", disp_pc_w, 32'h604);

        // rdy low freezes the queue
        push(I_ADDI, 32'h700);
        tick();
        idle();
        rdy_s = 1'b0;
        tick();
        check_val("rdy_low_pulse", rob_alloc_w, 1'b0);
        check_val("rdy_low_head", dec_inst_w, I_ADDI);
        idle();
        tick();
        check_val("rdy_back_pc", disp_pc_w, 32'h700);

        for (int c = 0; c < 1500; c++) begin
            valid_s    = ($urandom_range(0, 9) < 6);
            inst_s     = rand_inst();
            pc_s       = $urandom;
            pred_s     = 1'($urandom_range(0, 1));
            rob_full_s = ($urandom_range(0, 9) < 2);
            rs_full_s  = ($urandom_range(0, 9) < 2);
            lsb_full_s = ($urandom_range(0, 9) < 2);
            tag_s      = ROB_IDX_W'($urandom);
            done_s     = ($urandom_range(0, 9) == 0);
            flush_s    = ($urandom_range(0, 49) == 0);
            rdy_s      = ($urandom_range(0, 9) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
